// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter and its scoreboard.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  // Bit positions in the grant vector
  localparam int unsigned WB_SRC_P0 = 0;
  localparam int unsigned WB_SRC_P1 = 1;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-register bitmap for long-latency results, plus the decode hazard lookup.
module wb_scoreboard
  import wb_port_arbiter_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] rd1_addr_i,
  input  logic [REG_ADDR_W-1:0] rd2_addr_i,
  input  logic                  re1_i,
  input  logic                  re2_i,
  output logic                  hazard_stall_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_i) begin
      pend_d[clr_addr_i] = 1'b0;
    end
    // Applied after the clear so a newly issued op to the same register stays pending
    if (set_i && (set_addr_i != '0)) begin
      pend_d[set_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign hazard_stall_o = (re1_i & pend_q[rd1_addr_i]) | (re2_i & pend_q[rd2_addr_i]);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between P0 (pipeline) and P1 (long latency),
// with starvation protection for P1 and a registered write output.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  p0_valid,
  input  logic [REG_ADDR_W-1:0] p0_addr,
  input  logic [XLEN-1:0]       p0_data,
  output logic                  p0_ready,
  input  logic                  p1_valid,
  input  logic [REG_ADDR_W-1:0] p1_addr,
  input  logic [XLEN-1:0]       p1_data,
  output logic                  p1_ready,
  input  logic                  sb_set,
  input  logic [REG_ADDR_W-1:0] sb_addr,
  input  logic [REG_ADDR_W-1:0] rd1_addr,
  input  logic [REG_ADDR_W-1:0] rd2_addr,
  input  logic                  re1,
  input  logic                  re2,
  output logic                  hazard_stall,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic [XLEN-1:0]       wb_wdata
);

  logic [1:0]            grant;
  logic                  starved;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  wb_we_q, wb_we_d;
  logic [REG_ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
  logic [XLEN-1:0]       wb_wdata_q, wb_wdata_d;

  assign starved = (starve_cnt_q == CNT_W'(STARVE_MAX));

  // Grants are masked while reset is held so nothing is accepted into a clearing pipeline
  always_comb begin
    grant = 2'b00;
    if (reset_n) begin
      if (p1_valid && (!p0_valid || starved)) begin
        grant[WB_SRC_P1] = 1'b1;
      end else if (p0_valid) begin
        grant[WB_SRC_P0] = 1'b1;
      end
    end
  end

  assign p0_ready = grant[WB_SRC_P0];
  assign p1_ready = grant[WB_SRC_P1];

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (p1_valid && !grant[WB_SRC_P1]) begin
      if (!starved) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end else begin
      starve_cnt_d = '0;
    end
  end

  // Writes to x0 still consume the slot but never reach the register file
  always_comb begin
    wb_we_d    = 1'b0;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    if (grant[WB_SRC_P1]) begin
      wb_we_d    = (p1_addr != '0);
      wb_waddr_d = p1_addr;
      wb_wdata_d = p1_data;
    end else if (grant[WB_SRC_P0]) begin
      wb_we_d    = (p0_addr != '0);
      wb_waddr_d = p0_addr;
      wb_wdata_d = p0_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
      wb_we_q      <= 1'b0;
      wb_waddr_q   <= '0;
      wb_wdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wb_we_q      <= wb_we_d;
      wb_waddr_q   <= wb_waddr_d;
      wb_wdata_q   <= wb_wdata_d;
    end
  end

  assign wb_we    = wb_we_q;
  assign wb_waddr = wb_waddr_q;
  assign wb_wdata = wb_wdata_q;

  wb_scoreboard u_sb (
    .clk_i          (clk),
    .rst_ni         (reset_n),
    .set_i          (sb_set),
    .set_addr_i     (sb_addr),
    .clr_i          (grant[WB_SRC_P1]),
    .clr_addr_i     (p1_addr),
    .rd1_addr_i     (rd1_addr),
    .rd2_addr_i     (rd2_addr),
    .re1_i          (re1),
    .re2_i          (re2),
    .hazard_stall_o (hazard_stall)
  );

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two requesters: P0 (in-order pipeline writeback) and P1 (long-latency unit, e.g. mul/div or load return).
- Arbitrates between them, registers the winning write onto wb_we/wb_waddr/wb_wdata, and keeps a scoreboard of registers awaiting a P1 result.
- Decode uses the scoreboard-derived hazard_stall to hold dependent instructions.
- Sits between the execute/memory stages and the register file write inputs.

Parameters:
- STARVE_MAX, 4, consecutive cycles P1 may be refused while valid before it is forced to win (1..15).
- CNT_W, 4, width of the starvation counter; must hold STARVE_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- p0_valid  input  1  P0 write request.
- p0_addr  input  5  P0 destination register.
- p0_data  input  32  P0 write data.
- p0_ready  output  1  P0 request accepted this cycle.
- p1_valid  input  1  P1 write request.
- p1_addr  input  5  P1 destination register.
- p1_data  input  32  P1 write data.
- p1_ready  output  1  P1 request accepted this cycle.
- sb_set  input  1  long-latency op issued; mark destination pending.
- sb_addr  input  5  destination of issued long-latency op.
- rd1_addr  input  5  decode read port 1 address.
- rd2_addr  input  5  decode read port 2 address.
- re1  input  1  read port 1 enable.
- re2  input  1  read port 2 enable.
- hazard_stall  output  1  a read source is pending in the scoreboard.
- wb_we  output  1  register file write enable (registered).
- wb_waddr  output  5  register file write address (registered).
- wb_wdata  output  32  register file write data (registered).

Behaviour:
- Reset (reset_n low, asynchronous): wb_we=0, wb_waddr=0, wb_wdata=0, pend[31:0]=0, starve_cnt=0. Any write in flight or pending mark is discarded. p0_ready, p1_ready and hazard_stall are combinational and read 0 while reset is asserted.
- Grant (combinational):
  - Default P0 priority.
  - P1 wins if p1_valid and (!p0_valid or starve_cnt==STARVE_MAX).
  - At most one ready is high per cycle. ready is asserted only with the matching valid.
  - A request is accepted on the cycle valid&ready are both high. A requester holds valid, addr and data stable until accepted.
- Starvation counter:
  - Increments when p1_valid and !p1_ready.
  - Clears when P1 is accepted or p1_valid is low.
  - Saturates at STARVE_MAX.
- Output register: the accepted request in cycle N drives wb_we=1, wb_waddr, wb_wdata in cycle N+1. Latency is 1 cycle.
- No acceptance in cycle N gives wb_we=0 in N+1; addr and data hold their previous values.
- Address 0: the request is accepted normally (ready asserted, arbitration slot consumed), but wb_we is forced 0.
- Scoreboard:
  - pend[sb_addr] is set at the edge when sb_set=1 and sb_addr!=0.
  - pend[p1_addr] clears at the edge when P1 is accepted.
  - Set and clear of the same address in one cycle: set wins, so the new op stays pending.
  - Set on an already-pending address: the bit stays 1.
  - P0 acceptance never touches pend.
- hazard_stall = (re1 & pend[rd1_addr]) | (re2 & pend[rd2_addr]). Address 0 is never pending.
- Timing with the register file bypass: P1 is accepted in cycle N. hazard_stall can still be 1 in N. In N+1 pend has cleared and wb_we targets the same address, so the register file's same-cycle write bypass supplies the data.
- Back-to-back acceptances every cycle are allowed; full throughput is one write per cycle.

Decomposition:
- Shared package:
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32.
  - Requester index constants (WB_SRC_P0=0, WB_SRC_P1=1).
- Natural sub-module: wb_scoreboard, holding the pend bitmap with set/clear/lookup ports and the hazard_stall logic. The arbiter, starvation counter and output register remain in wb_port_arbiter.

Test Plan:
- Reset mid-transfer:
  - Stimulus: sb_set addr 7, then p0 write addr 3 data 0x11, then assert reset_n=0 for one cycle.
  - Required: wb_we=0, pend=0, hazard_stall=0 immediately.
- Single writes:
  - p0 addr 5 data 0xDEADBEEF alone: p0_ready=1 in N; wb_we=1, wb_waddr=5, wb_wdata=0xDEADBEEF in N+1; wb_we=0 in N+2.
  - p0 addr 0 data 0x1234: p0_ready=1; wb_we stays 0.
- Contention and starvation, STARVE_MAX=4:
  - Stimulus: p0 and p1 both valid continuously.
  - Required: P0 is granted for 4 cycles, P1 in the 5th, then the pattern repeats. wb_waddr sequence matches the grant order.
- Scoreboard hazard:
  - Stimulus: sb_set addr 9; re1=1, rd1_addr=9.
  - Required: hazard_stall=1 until P1 write addr 9 is accepted in cycle N; hazard_stall=0 in N+1 with wb_we=1, wb_waddr=9.
- Scoreboard collision:
  - Stimulus: in the same cycle, sb_set addr 12 and P1 accepted addr 12.
  - Required: pend[12] remains 1 and hazard_stall stays 1 for rd2_addr=12, re2=1.
  - Stimulus: sb_set addr 0.
  - Required: no bit set.
